// File: rtl/io_input_ctl_if.sv
// Processor-side data-memory bus seen by the input controller: address, strobes,
// write data, and the combinational read data / select returned to the read mux.
interface io_input_ctl_if #(
  parameter int DBITS = 16
);
  logic [DBITS-1:0] addr;
  logic             re;
  logic             we;
  logic [DBITS-1:0] din;
  logic [DBITS-1:0] dout;
  logic             sel;

  modport master (output addr, re, we, din, input dout, sel);
  modport slave  (input addr, re, we, din, output dout, sel);
endinterface

// File: rtl/io_input_ctl.sv
// io_input_ctl: synchronizes KEY/SW, debounces them and exposes KDATA/SDATA/KCTRL/SCTRL.
// Define IO_DEBOUNCE_EN for per-bit debounce counters; otherwise bits are only synchronized.
module io_input_ctl #(
  parameter int DBITS           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNTBITS         = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic [9:0] sw,
  io_input_ctl_if.slave bus
);
  localparam logic [DBITS-1:0] ADDR_KDATA = DBITS'(16'hFFF0);
  localparam logic [DBITS-1:0] ADDR_SDATA = DBITS'(16'hFFF2);
  localparam logic [DBITS-1:0] ADDR_KCTRL = DBITS'(16'hFFF4);
  localparam logic [DBITS-1:0] ADDR_SCTRL = DBITS'(16'hFFF6);
  // Raw reset level: keys released (high), switches off.
  localparam logic [13:0]      SYNC_RST   = {10'b0, 4'hF};

  if (DEBOUNCE_CYCLES < 1 || (DEBOUNCE_CYCLES >> CNTBITS) != 0) begin : g_bad_cfg
    $error("io_input_ctl: CNTBITS too narrow for DEBOUNCE_CYCLES");
  end

  logic [13:0] sync1_reg;
  logic [13:0] sync2_reg;
  logic [13:0] in_sync;
  logic [13:0] db_vec;
  logic [13:0] upd;
  logic        krdy_reg;
  logic        kovr_reg;
  logic        srdy_reg;
  logic        sovr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= SYNC_RST;
      sync2_reg <= SYNC_RST;
    end else begin
      sync1_reg <= {sw, key};
      sync2_reg <= sync1_reg;
    end
  end

  // Bits [3:0] become pressed = 1 after the synchronizer.
  assign in_sync = {sync2_reg[13:4], ~sync2_reg[3:0]};

`ifdef IO_DEBOUNCE_EN
  localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBOUNCE_CYCLES - 1);

  genvar gi;
  generate
    for (gi = 0; gi < 14; gi++) begin : g_db
      logic [CNTBITS-1:0] cnt_reg;
      logic               db_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
          db_reg  <= 1'b0;
        end else if (in_sync[gi] == db_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
          cnt_reg <= '0;
          db_reg  <= in_sync[gi];
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign db_vec[gi] = db_reg;
      assign upd[gi]    = (in_sync[gi] != db_reg) && (cnt_reg == CNT_LAST);
    end
  endgenerate
`else
  logic [13:0] db_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) db_reg <= '0;
    else     db_reg <= in_sync;
  end

  assign db_vec = db_reg;
  assign upd    = in_sync ^ db_reg;
`endif

  logic key_chg, sw_chg;
  logic k_rd, s_rd, k_ovr_clr, s_ovr_clr;

  assign key_chg   = |upd[3:0];
  assign sw_chg    = |upd[13:4];
  assign k_rd      = bus.re && (bus.addr == ADDR_KDATA);
  assign s_rd      = bus.re && (bus.addr == ADDR_SDATA);
  assign k_ovr_clr = bus.we && (bus.addr == ADDR_KCTRL) && !bus.din[1];
  assign s_ovr_clr = bus.we && (bus.addr == ADDR_SCTRL) && !bus.din[1];

  // A change coinciding with a clearing read counts as consumed-then-new, not an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      krdy_reg <= 1'b0;
      kovr_reg <= 1'b0;
      srdy_reg <= 1'b0;
      sovr_reg <= 1'b0;
    end else begin
      krdy_reg <= key_chg | (krdy_reg & ~k_rd);
      kovr_reg <= (key_chg & krdy_reg & ~k_rd) | (kovr_reg & ~k_ovr_clr);
      srdy_reg <= sw_chg | (srdy_reg & ~s_rd);
      sovr_reg <= (sw_chg & srdy_reg & ~s_rd) | (sovr_reg & ~s_ovr_clr);
    end
  end

  always_comb begin
    bus.dout = DBITS'(16'hDEAD);
    bus.sel  = 1'b0;
    case (bus.addr)
      ADDR_KDATA: begin bus.dout = DBITS'(db_vec[3:0]);                bus.sel = 1'b1; end
      ADDR_SDATA: begin bus.dout = DBITS'(db_vec[13:4]);               bus.sel = 1'b1; end
      ADDR_KCTRL: begin bus.dout = DBITS'({kovr_reg, krdy_reg});       bus.sel = 1'b1; end
      ADDR_SCTRL: begin bus.dout = DBITS'({sovr_reg, srdy_reg});       bus.sel = 1'b1; end
      default:    begin bus.dout = DBITS'(16'hDEAD);                   bus.sel = 1'b0; end
    endcase
  end

  wire unused_din = ^{bus.din[DBITS-1:2], bus.din[0]};
endmodule

// File: tb/tb_io_input_ctl.sv
// Self-checking bench for io_input_ctl: directed scenarios plus randomized traffic,
// compared every cycle against a sliding-window reference model of the debounce rules.
module tb_io_input_ctl;
  localparam int N = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int W = N;
`else
  localparam int W = 1;
`endif
  localparam int LAT = W + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic [9:0] sw;
  int         n_checks = 0;
  int         n_pass   = 0;

  io_input_ctl_if #(.DBITS(16)) bus();

  io_input_ctl #(.DBITS(16), .DEBOUNCE_CYCLES(N), .CNTBITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .key (key),
    .sw  (sw),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: debounced bit flips once the last W synchronized samples all disagree with it.
  logic [13:0] m_db;
  logic        m_krdy, m_kovr, m_srdy, m_sovr;
  logic [13:0] m_hist[$];

  task automatic m_reset();
    m_db = '0;
    m_krdy = 1'b0; m_kovr = 1'b0; m_srdy = 1'b0; m_sovr = 1'b0;
    m_hist.delete();
    for (int i = 0; i < W + 2; i++) m_hist.push_back(14'b0);
  endtask

  task automatic model_edge(input logic [3:0] k, input logic [9:0] s, input logic [15:0] a,
                            input logic r, input logic w, input logic [15:0] d);
    logic [13:0] nd;
    bit all_diff, kchg, schg, krd, srd, kclr, sclr;
    m_hist.push_back({s, ~k});
    if (m_hist.size() > W + 2) void'(m_hist.pop_front());
    nd = m_db;
    for (int b = 0; b < 14; b++) begin
      all_diff = 1'b1;
      for (int i = 0; i < W; i++) if (m_hist[i][b] == m_db[b]) all_diff = 1'b0;
      if (all_diff) nd[b] = ~m_db[b];
    end
    kchg = (nd[3:0] != m_db[3:0]);
    schg = (nd[13:4] != m_db[13:4]);
    krd  = r && (a == 16'hFFF0);
    srd  = r && (a == 16'hFFF2);
    kclr = w && (a == 16'hFFF4) && !d[1];
    sclr = w && (a == 16'hFFF6) && !d[1];
    m_kovr = (kchg && m_krdy && !krd) ? 1'b1 : (kclr ? 1'b0 : m_kovr);
    m_krdy = kchg ? 1'b1 : (krd ? 1'b0 : m_krdy);
    m_sovr = (schg && m_srdy && !srd) ? 1'b1 : (sclr ? 1'b0 : m_sovr);
    m_srdy = schg ? 1'b1 : (srd ? 1'b0 : m_srdy);
    m_db = nd;
  endtask

  function automatic logic [15:0] exp_dout(input logic [15:0] a);
    case (a)
      16'hFFF0: return {12'b0, m_db[3:0]};
      16'hFFF2: return {6'b0, m_db[13:4]};
      16'hFFF4: return {14'b0, m_kovr, m_krdy};
      16'hFFF6: return {14'b0, m_sovr, m_srdy};
      default:  return 16'hDEAD;
    endcase
  endfunction

  function automatic logic exp_sel(input logic [15:0] a);
    return (a == 16'hFFF0) || (a == 16'hFFF2) || (a == 16'hFFF4) || (a == 16'hFFF6);
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // One bus cycle: drive, check at negedge, advance the model at the posedge.
  task automatic cyc(input logic [15:0] a, input logic r, input logic w, input logic [15:0] d,
                     input string tag, input bit use_c, input logic [15:0] cval);
    bus.addr = a; bus.re = r; bus.we = w; bus.din = d;
    @(negedge clk);
    $display("t=%0t key=%h sw=%h addr=%h re=%b we=%b din=%h dout=%h sel=%b",
             $time, key, sw, a, r, w, d, bus.dout, bus.sel);
    check({tag, "_model"}, bus.dout, exp_dout(a));
    check({tag, "_sel"}, {15'b0, bus.sel}, {15'b0, exp_sel(a)});
    if (use_c) check(tag, bus.dout, cval);
    @(posedge clk);
    model_edge(key, sw, a, r, w, d);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    bus.addr = 16'hFFF6; bus.re = 1'b0; bus.we = 1'b0; bus.din = 16'h0;
    #1;
    check("rst_sctrl", bus.dout, 16'h0000);
    bus.addr = 16'hFFF2;
    #1;
    check("rst_sdata", bus.dout, 16'h0000);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [15:0] ra;
    rst = 1'b1; key = 4'hF; sw = 10'h0;
    bus.addr = 16'h0; bus.re = 1'b0; bus.we = 1'b0; bus.din = 16'h0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and unmapped read.
    cyc(16'hFFF0, 0, 0, 0, "rst_kdata", 1, 16'h0000);
    cyc(16'hFFF2, 0, 0, 0, "rst_sdata0", 1, 16'h0000);
    cyc(16'hFFF4, 0, 0, 0, "rst_kctrl", 1, 16'h0000);
    cyc(16'h1234, 0, 0, 0, "unmapped", 1, 16'hDEAD);

    // Press KEY[0]: exact latency.
    key = 4'hE;
    for (int i = 0; i <= LAT; i++)
      cyc(16'hFFF0, 0, 0, 0, "lat_kdata", 1, (i >= LAT) ? 16'h0001 : 16'h0000);
    cyc(16'hFFF4, 0, 0, 0, "lat_kctrl", 1, 16'h0001);
    key = 4'hF;
    repeat (LAT + 1) cyc(16'hFFF4, 0, 0, 0, "rel", 0, 16'h0);
    cyc(16'hFFF4, 0, 0, 0, "rel_kctrl", 1, 16'h0003);
    cyc(16'hFFF0, 1, 0, 0, "clr_rd", 1, 16'h0000);
    cyc(16'hFFF4, 0, 1, 0, "clr_wr", 1, 16'h0002);
    cyc(16'hFFF4, 0, 0, 0, "clr_kctrl", 1, 16'h0000);

    // Short glitch on KEY[0] is rejected when debouncing.
    key = 4'hE;
    repeat (3) cyc(16'hFFF0, 0, 0, 0, "glitch_kdata", W > 1, 16'h0000);
    key = 4'hF;
    repeat (LAT + 3) cyc(16'hFFF4, 0, 0, 0, "glitch_kctrl", W > 1, 16'h0000);
    cyc(16'hFFF0, 1, 0, 0, "glitch_drain", 0, 16'h0);
    cyc(16'hFFF4, 0, 1, 0, "glitch_drain2", 0, 16'h0);

    // Press and release KEY[1] without reading: overrun, then read and write clears.
    key = 4'hD;
    repeat (LAT + 1) cyc(16'hFFF2, 0, 0, 0, "k1_press", 0, 16'h0);
    key = 4'hF;
    repeat (LAT + 1) cyc(16'hFFF2, 0, 0, 0, "k1_release", 0, 16'h0);
    cyc(16'hFFF4, 0, 0, 0, "k1_ovr", 1, 16'h0003);
    cyc(16'hFFF4, 0, 1, 16'h0002, "k1_wr1", 1, 16'h0003);
    cyc(16'hFFF0, 1, 0, 0, "k1_rd", 1, 16'h0000);
    cyc(16'hFFF4, 0, 0, 0, "k1_after_rd", 1, 16'h0002);
    cyc(16'hFFF4, 0, 1, 16'h0000, "k1_wr0", 1, 16'h0002);
    cyc(16'hFFF4, 0, 0, 0, "k1_clr", 1, 16'h0000);

    // Switch change with a clearing read on the very edge sdb changes.
    sw = 10'h3FF;
    for (int i = 0; i < LAT; i++)
      cyc(16'hFFF2, (i == LAT - 1), 0, 0, "sw_wait", 0, 16'h0);
    cyc(16'hFFF6, 0, 0, 0, "sw_sctrl", 1, 16'h0001);
    cyc(16'hFFF2, 1, 0, 0, "sw_sdata", 1, 16'h03FF);
    cyc(16'hFFF6, 0, 0, 0, "sw_clr", 1, 16'h0000);

    // Reset mid-debounce restarts the full latency.
    sw = 10'h155;
    repeat (3) cyc(16'hFFF2, 0, 0, 0, "sw_pre", 0, 16'h0);
    do_reset();
    for (int i = 0; i <= LAT; i++)
      cyc(16'hFFF2, 0, 0, 0, "rst_lat", 1, (i >= LAT) ? 16'h0155 : 16'h0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(5) == 0) key = 4'($urandom);
      if ($urandom_range(5) == 0) sw  = 10'($urandom);
      case ($urandom_range(4))
        0: ra = 16'hFFF0;
        1: ra = 16'hFFF2;
        2: ra = 16'hFFF4;
        3: ra = 16'hFFF6;
        default: ra = 16'($urandom);
      endcase
      if ($urandom_range(399) == 0) do_reset();
      else cyc(ra, ($urandom_range(3) == 0), ($urandom_range(5) == 0), 16'($urandom),
               "rnd", 0, 16'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/io_input_ctl.md
# io_input_ctl

Memory-mapped input controller for the push-buttons and slide switches. It sits directly upstream of the processor's data-memory read mux, replacing the raw KEY/SW taps at 16'hFFF0/16'hFFF2. It synchronizes and debounces the raw inputs and presents the clean values as registers. A sticky ready/overrun status register lets programs poll for key events instead of sampling raw levels.

## Interface
Parameters:
- DBITS, 16, data/address bus width
- DEBOUNCE_CYCLES, 500000, number of consecutive stable cycles required before a debounced bit changes
- CNTBITS, 20, width of each debounce counter; must satisfy 2^CNTBITS > DEBOUNCE_CYCLES

Ports (one clock, CLK; reset is asynchronous and active-high, RESET):
- CLK  in  1  system clock (PLL c0)
- RESET  in  1  asynchronous, active-high reset
- KEY  in  4  raw push-buttons, active-low (0 = pressed)
- SW  in  10  raw slide switches, active-high
- ADDR  in  DBITS  data address (the processor's dmemaddr)
- RE  in  1  read strobe; high for the cycle in which a load consumes DOUT
- WE  in  1  write strobe (the processor's bwrmem)
- DIN  in  DBITS  write data
- DOUT  out  DBITS  read data, combinational from ADDR
- SEL  out  1  high when ADDR is one of the four mapped addresses

## Operation
- Register map:
  - 16'hFFF0 KDATA: {12'b0, kdb[3:0]}; kdb bit = 1 means pressed.
  - 16'hFFF2 SDATA: {6'b0, sdb[9:0]}.
  - 16'hFFF4 KCTRL: {14'b0, kovr, krdy}.
  - 16'hFFF6 SCTRL: {14'b0, sovr, srdy}.
  - Any other ADDR: DOUT = 16'hDEAD, SEL = 0.
- Synchronizer:
  - 2-flop synchronizer on every raw bit.
  - KEY is inverted after synchronization.
  - Synchronizer flops reset to the "released/off" raw level: KEY flops to 1, SW flops to 0.
- Debounce, per bit, 14 independent counters:
  - If the synchronized bit equals the debounced bit, the counter is cleared to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the bits still differ, the debounced bit takes the synchronized value and the counter clears in that same cycle.
- Event flags (keys shown; switches identical with sdb/srdy/sovr):
  - chg = kdb changes value this cycle (any bit).
  - krdy is set on chg.
  - krdy is cleared on (RE && ADDR==16'hFFF0), i.e. a read of KDATA.
  - If chg and a clearing read occur in the same cycle, krdy = 1 and kovr is unaffected.
  - If chg occurs while krdy = 1 with no clearing read, kovr is set.
  - kovr is cleared by (WE && ADDR==16'hFFF4 && DIN[1]==0).
  - If a set condition and a clear of kovr occur in the same cycle, kovr = 1.
  - Writes to KCTRL bit 0, writes to KDATA/SDATA, and writes to unmapped addresses have no effect.
  - RE with a non-data address has no side effect.
- Reset values (asynchronous, immediate):
  - kdb = 0, sdb = 0.
  - All counters = 0.
  - krdy, kovr, srdy, sovr = 0.
  - Resulting DOUT at 16'hFFF4 = 16'h0000.
  - SEL and DOUT stay purely combinational from ADDR and registered state.
- Reset asserted mid-debounce discards any count in progress. After release, a held input requires the full latency again.

## Timing
- Raw-to-debounced latency: exactly 2 + DEBOUNCE_CYCLES clock edges from the first edge that samples the new raw level, provided the input stays stable throughout. Any glitch resets the count.
- krdy/srdy rise on the same edge the debounced bit changes.
- Read path:
  - DOUT is valid in the same cycle ADDR is presented, with no wait state.
  - The clearing side effect takes place at the edge ending the RE cycle.
  - A read in cycle N returns pre-clear data; a read of KCTRL in cycle N+1 shows krdy = 0.
- Write path: the effect is visible at DOUT in the cycle after the WE edge.

## Configuration
- IO_DEBOUNCE_EN defined:
  - Full per-bit debounce as described.
  - Latency is 2 + DEBOUNCE_CYCLES.
- IO_DEBOUNCE_EN undefined:
  - Counters are not instantiated.
  - kdb/sdb are registered copies of the synchronized bits.
  - Latency is 3 edges.
  - Flags and the register map are unchanged.

## Test plan
Bench uses DEBOUNCE_CYCLES = 4 with IO_DEBOUNCE_EN defined unless stated.
- Reset, then read 16'hFFF0, 16'hFFF2, 16'hFFF4 with KEY = 4'hF, SW = 0 -> 16'h0000 each. Read 16'h1234 -> 16'hDEAD, SEL = 0.
- KEY falls from 4'hF to 4'hE and is held -> KDATA = 16'h0001 and KCTRL = 16'h0001 exactly 6 edges later, not earlier.
- KEY[0] toggles low for 3 cycles then returns high -> KDATA stays 0, krdy stays 0.
- Press KEY[1]; without reading KDATA, release it -> KCTRL = 16'h0003. Read KDATA with RE -> next cycle KCTRL = 16'h0002. Write 16'h0000 to 16'hFFF4 -> KCTRL = 16'h0000.
- SW = 10'h3FF held, with RE on 16'hFFF2 pulsed on the very edge sdb changes -> SCTRL = 16'h0001, sovr = 0.
- Assert RESET after 3 stable cycles of a new SW value -> all flags 0, sdb = 0; debounce restarts from 0 after release. Rerun with IO_DEBOUNCE_EN undefined -> change is visible after 3 edges.
